// File: rtl/sent_pkg.sv
// sent_pkg: shared definitions for the SENT command dispatcher.
//   state_t        dispatcher FSM states
//   CMD_CONFIG/
//   CMD_FRAME      command-type encodings carried in cmd_type
//   *_LSB          bit offsets of the fields inside the 35-bit payload
//   cmd_t          one queued command {type, channel, payload}, 44 bits
package sent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic CMD_CONFIG = 1'b0;
    localparam logic CMD_FRAME  = 1'b1;

    localparam int unsigned PAYLOAD_W = 35;

    // Config payload layout: {ctick[34:27], ltick[26:19], pause_mode[18:17],
    // pause_len[16:1], crc_mode[0]}. Frame data sits in [31:0].
    localparam int unsigned CTICK_LSB = 27;
    localparam int unsigned LTICK_LSB = 19;
    localparam int unsigned PMODE_LSB = 17;
    localparam int unsigned PLEN_LSB  = 1;
    localparam int unsigned CRC_LSB   = 0;
    localparam int unsigned FDATA_LSB = 0;

    typedef struct packed {
        logic                 ctype;
        logic [7:0]           channel;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sent_dispatch_if.sv
// sent_dispatch_if: command write port, per-channel status, channel strobes
// and sticky error flags of the SENT dispatcher.
//   master : command source / channel side (drives cmd_*, sent_ready,
//            sent_fifo_pfull, err_clr)
//   slave  : the dispatcher (drives cmd_full, strobes, fields, err_*)
interface sent_dispatch_if #(
    parameter int unsigned SENT_NUM = 1
);
    logic                cmd_vld;
    logic                cmd_type;
    logic [7:0]          cmd_channel;
    logic [34:0]         cmd_payload;
    logic                cmd_full;

    logic [SENT_NUM-1:0] sent_ready;
    logic [SENT_NUM-1:0] sent_fifo_pfull;

    logic                sent_config_vld;
    logic                sent_frame_vld;
    logic [7:0]          sent_config_channel;
    logic [7:0]          sent_ctick_len;
    logic [7:0]          sent_ltick_len;
    logic [1:0]          sent_pause_mode;
    logic [15:0]         sent_pause_len;
    logic                sent_crc_mode;
    logic [31:0]         sent_frame_data;

    logic                err_overflow;
    logic                err_badch;
    logic                err_timeout;
    logic                err_clr;

    modport master (
        output cmd_vld, cmd_type, cmd_channel, cmd_payload,
        output sent_ready, sent_fifo_pfull, err_clr,
        input  cmd_full,
        input  sent_config_vld, sent_frame_vld, sent_config_channel,
        input  sent_ctick_len, sent_ltick_len, sent_pause_mode,
        input  sent_pause_len, sent_crc_mode, sent_frame_data,
        input  err_overflow, err_badch, err_timeout
    );

    modport slave (
        input  cmd_vld, cmd_type, cmd_channel, cmd_payload,
        input  sent_ready, sent_fifo_pfull, err_clr,
        output cmd_full,
        output sent_config_vld, sent_frame_vld, sent_config_channel,
        output sent_ctick_len, sent_ltick_len, sent_pause_mode,
        output sent_pause_len, sent_crc_mode, sent_frame_data,
        output err_overflow, err_badch, err_timeout
    );

endinterface

// File: rtl/sent_cmd_fifo.sv
// sent_cmd_fifo: synchronous command queue with show-ahead head output.
//   clk, rst  clock, asynchronous active-high reset (clears pointers/count)
//   wr_en     write request; accepted when not full, or when full and a
//             pop happens in the same cycle
//   wr_data   entry to store
//   rd_en     pop the head (ignored when empty)
//   rd_data   current head, valid whenever empty is low
//   full      DEPTH entries stored
//   empty     no entries stored
module sent_cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        rd_data = mem_q[rd_ptr_q];
    end

    always_comb begin
        do_rd = rd_en && !empty;
        // When full, the slot being written is the one being popped; the
        // head is read before the edge, so the overwrite is safe.
        do_wr = wr_en && (!full || do_rd);

        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/sent_dispatch.sv
// sent_dispatch: queues config/frame commands and issues them in order to
// SENT channels, waiting for each channel's readiness.
//   clk, rst  clock, asynchronous active-high reset
//   bus       sent_dispatch_if slave port:
//             cmd_vld/cmd_type/cmd_channel/cmd_payload -> command write
//             cmd_full                                 <- queue full
//             sent_ready/sent_fifo_pfull               -> channel status
//             sent_config_vld/sent_frame_vld + fields  <- one-cycle strobes
//             err_overflow/err_badch/err_timeout       <- sticky errors
//             err_clr                                  -> clear errors
module sent_dispatch
    import sent_pkg::*;
#(
    parameter int unsigned SENT_NUM    = 1,
    parameter int unsigned CMD_DEPTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    sent_dispatch_if.slave bus
);

    cmd_t        wr_cmd, head;
    logic        fifo_full, fifo_empty, pop;
    logic        head_ch_ok, head_ready, head_pfull, head_elig;
    logic        set_ovf, set_badch, set_tmo;

    state_t      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic        cfg_vld_q, cfg_vld_d;
    logic        frm_vld_q, frm_vld_d;
    logic [7:0]  chan_q, chan_d;
    logic [7:0]  ctick_q, ctick_d;
    logic [7:0]  ltick_q, ltick_d;
    logic [1:0]  pmode_q, pmode_d;
    logic [15:0] plen_q, plen_d;
    logic        crc_q, crc_d;
    logic [31:0] fdata_q, fdata_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_badch_q, err_badch_d;
    logic        err_tmo_q, err_tmo_d;

    always_comb begin
        wr_cmd.ctype   = bus.cmd_type;
        wr_cmd.channel = bus.cmd_channel;
        wr_cmd.payload = bus.cmd_payload;
    end

    sent_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.cmd_vld),
        .wr_data (wr_cmd),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Status of the head's channel; out-of-range channels read as blocked
    // but are filtered by head_ch_ok before eligibility matters.
    always_comb begin
        head_ready = 1'b0;
        head_pfull = 1'b1;
        for (int unsigned i = 0; i < SENT_NUM; i++) begin
            if (head.channel == 8'(i)) begin
                head_ready = bus.sent_ready[i];
                head_pfull = bus.sent_fifo_pfull[i];
            end
        end
        head_ch_ok = (32'(head.channel) < SENT_NUM);
        head_elig  = (head.ctype == CMD_CONFIG) ? head_ready : !head_pfull;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        set_badch  = 1'b0;
        set_tmo    = 1'b0;
        cfg_vld_d  = 1'b0;
        frm_vld_d  = 1'b0;
        chan_d     = chan_q;
        ctick_d    = ctick_q;
        ltick_d    = ltick_q;
        pmode_d    = pmode_q;
        plen_d     = plen_q;
        crc_d      = crc_q;
        fdata_d    = fdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (!head_ch_ok) begin
                    pop       = 1'b1;
                    set_badch = 1'b1;
                    state_d   = ST_IDLE;
                end else if (head_elig) begin
                    // Strobe and fields are registered here so they appear
                    // during the ISSUE cycle.
                    state_d = ST_ISSUE;
                    chan_d  = head.channel;
                    if (head.ctype == CMD_CONFIG) begin
                        cfg_vld_d = 1'b1;
                        ctick_d   = head.payload[CTICK_LSB +: 8];
                        ltick_d   = head.payload[LTICK_LSB +: 8];
                        pmode_d   = head.payload[PMODE_LSB +: 2];
                        plen_d    = head.payload[PLEN_LSB +: 16];
                        crc_d     = head.payload[CRC_LSB];
                    end else begin
                        frm_vld_d = 1'b1;
                        fdata_d   = head.payload[FDATA_LSB +: 32];
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (wait_cnt_q + 32'd1 == TIMEOUT_CYC) begin
                        pop     = 1'b1;
                        set_tmo = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
                end
            end
            ST_ISSUE: begin
                pop     = 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        set_ovf     = bus.cmd_vld && fifo_full && !pop;
        err_ovf_d   = set_ovf   || (err_ovf_q   && !bus.err_clr);
        err_badch_d = set_badch || (err_badch_q && !bus.err_clr);
        err_tmo_d   = set_tmo   || (err_tmo_q   && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            cfg_vld_q   <= 1'b0;
            frm_vld_q   <= 1'b0;
            chan_q      <= '0;
            ctick_q     <= '0;
            ltick_q     <= '0;
            pmode_q     <= '0;
            plen_q      <= '0;
            crc_q       <= 1'b0;
            fdata_q     <= '0;
            err_ovf_q   <= 1'b0;
            err_badch_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cfg_vld_q   <= cfg_vld_d;
            frm_vld_q   <= frm_vld_d;
            chan_q      <= chan_d;
            ctick_q     <= ctick_d;
            ltick_q     <= ltick_d;
            pmode_q     <= pmode_d;
            plen_q      <= plen_d;
            crc_q       <= crc_d;
            fdata_q     <= fdata_d;
            err_ovf_q   <= err_ovf_d;
            err_badch_q <= err_badch_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    always_comb begin
        bus.cmd_full            = fifo_full;
        bus.sent_config_vld     = cfg_vld_q;
        bus.sent_frame_vld      = frm_vld_q;
        bus.sent_config_channel = chan_q;
        bus.sent_ctick_len      = ctick_q;
        bus.sent_ltick_len      = ltick_q;
        bus.sent_pause_mode     = pmode_q;
        bus.sent_pause_len      = plen_q;
        bus.sent_crc_mode       = crc_q;
        bus.sent_frame_data     = fdata_q;
        bus.err_overflow        = err_ovf_q;
        bus.err_badch           = err_badch_q;
        bus.err_timeout         = err_tmo_q;
    end

endmodule

// File: tb/tb_sent_dispatch.sv
`timescale 1ns/1ps
module tb_sent_dispatch;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 50;
    localparam int          NEVER = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sent_dispatch_if #(.SENT_NUM(N_CH)) bus();

    sent_dispatch #(
        .SENT_NUM    (N_CH),
        .CMD_DEPTH   (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total  = 0;
    int passed = 0;
    int tb_cyc = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Commands wait in a list; the dispatcher looks at the list, judges the
    // head every cycle until it goes, is dropped, or times out, and after a
    // strobe needs two more cycles before it looks again.
    typedef struct {
        bit          ctype;
        int          ch;
        logic [34:0] pl;
    } m_cmd_t;

    m_cmd_t mq[$];
    m_cmd_t mh, mn;
    int  cyc, look_at, eval_at, pop_at, waited;
    bit  popping, s_ovf, s_bad, s_tmo, accept, elig;
    bit  e_cfg, e_frm, e_full, e_ovf, e_bad, e_tmo, e_crc;
    logic [7:0]  e_ch, e_ctick, e_ltick;
    logic [1:0]  e_pmode;
    logic [15:0] e_plen;
    logic [31:0] e_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            cyc = 0; look_at = 0; eval_at = -1; pop_at = -1; waited = 0;
            e_cfg = 0; e_frm = 0; e_full = 0; e_ovf = 0; e_bad = 0; e_tmo = 0;
            e_ch = '0; e_ctick = '0; e_ltick = '0; e_pmode = '0; e_plen = '0;
            e_crc = 0; e_data = '0;
        end else begin
            popping = 0; s_ovf = 0; s_bad = 0; s_tmo = 0;
            e_cfg = 0; e_frm = 0;
            if (cyc >= look_at) begin
                if (mq.size() > 0) begin
                    look_at = NEVER; eval_at = cyc + 1; waited = 0;
                end
            end else if (eval_at == cyc) begin
                mh = mq[0];
                if (mh.ch >= int'(N_CH)) begin
                    popping = 1; s_bad = 1; look_at = cyc + 1;
                end else begin
                    elig = mh.ctype ? !bus.sent_fifo_pfull[mh.ch] : bus.sent_ready[mh.ch];
                    if (elig) begin
                        e_ch = 8'(mh.ch);
                        if (mh.ctype) begin
                            e_frm = 1; e_data = mh.pl[31:0];
                        end else begin
                            e_cfg = 1;
                            e_ctick = mh.pl[34:27]; e_ltick = mh.pl[26:19];
                            e_pmode = mh.pl[18:17]; e_plen = mh.pl[16:1]; e_crc = mh.pl[0];
                        end
                        pop_at = cyc + 1; look_at = cyc + 3;
                    end else begin
                        waited++;
                        if (TMO != 0 && waited == int'(TMO)) begin
                            popping = 1; s_tmo = 1; look_at = cyc + 1;
                        end else begin
                            eval_at = cyc + 1;
                        end
                    end
                end
            end
            if (pop_at == cyc) popping = 1;
            accept = bus.cmd_vld && (mq.size() < int'(DEPTH) || popping);
            s_ovf  = bus.cmd_vld && !accept;
            if (popping) void'(mq.pop_front());
            if (accept) begin
                mn.ctype = bus.cmd_type; mn.ch = int'(bus.cmd_channel); mn.pl = bus.cmd_payload;
                mq.push_back(mn);
            end
            e_full = (mq.size() == int'(DEPTH));
            e_ovf = s_ovf || (e_ovf && !bus.err_clr);
            e_bad = s_bad || (e_bad && !bus.err_clr);
            e_tmo = s_tmo || (e_tmo && !bus.err_clr);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cfg_vld",   64'(bus.sent_config_vld),     64'(e_cfg));
            chk("frm_vld",   64'(bus.sent_frame_vld),      64'(e_frm));
            chk("channel",   64'(bus.sent_config_channel), 64'(e_ch));
            chk("ctick",     64'(bus.sent_ctick_len),      64'(e_ctick));
            chk("ltick",     64'(bus.sent_ltick_len),      64'(e_ltick));
            chk("pmode",     64'(bus.sent_pause_mode),     64'(e_pmode));
            chk("plen",      64'(bus.sent_pause_len),      64'(e_plen));
            chk("crc",       64'(bus.sent_crc_mode),       64'(e_crc));
            chk("fdata",     64'(bus.sent_frame_data),     64'(e_data));
            chk("cmd_full",  64'(bus.cmd_full),            64'(e_full));
            chk("err_ovf",   64'(bus.err_overflow),        64'(e_ovf));
            chk("err_badch", 64'(bus.err_badch),           64'(e_bad));
            chk("err_tmo",   64'(bus.err_timeout),         64'(e_tmo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic t, input logic [7:0] ch, input logic [34:0] pl);
        bus.cmd_vld = 1'b1; bus.cmd_type = t; bus.cmd_channel = ch; bus.cmd_payload = pl;
        tick();
        bus.cmd_vld = 1'b0;
    endtask

    function automatic logic [34:0] mk_cfg(input logic [7:0] ct, input logic [7:0] lt,
                                           input logic [1:0] pm, input logic [15:0] pl,
                                           input logic crc);
        return {ct, lt, pm, pl, crc};
    endfunction

    function automatic logic [34:0] mk_frm(input logic [31:0] d);
        return {3'b101, d};
    endfunction

    function automatic bit strobe();
        return bus.sent_config_vld || bus.sent_frame_vld;
    endfunction

    task automatic wait_strobe(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!strobe() && n < bound);
        chk("strobe_seen", 64'(strobe()), 64'd1);
    endtask

    int n, t0, cnt;

    initial begin
        bus.cmd_vld = 1'b0; bus.cmd_type = 1'b0; bus.cmd_channel = '0; bus.cmd_payload = '0;
        bus.sent_ready = '1; bus.sent_fifo_pfull = '0; bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_full",    64'(bus.cmd_full),        64'd0);
        chk("rst_cfg_vld", 64'(bus.sent_config_vld), 64'd0);
        chk("rst_frm_vld", 64'(bus.sent_frame_vld),  64'd0);
        chk("rst_fdata",   64'(bus.sent_frame_data), 64'd0);
        chk("rst_errs",    64'({bus.err_overflow, bus.err_badch, bus.err_timeout}), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Config to ch0, eligible: strobe three cycles after the write.
        put(1'b0, 8'd0, mk_cfg(8'd10, 8'h20, 2'd2, 16'h1234, 1'b1));
        tick();
        chk("t1_no_early", 64'(bus.sent_config_vld), 64'd0);
        tick();
        chk("t1_cfg_vld", 64'(bus.sent_config_vld),     64'd1);
        chk("t1_ctick",   64'(bus.sent_ctick_len),      64'd10);
        chk("t1_chan",    64'(bus.sent_config_channel), 64'd0);
        chk("t1_plen",    64'(bus.sent_pause_len),      64'h1234);
        chk("t1_pmode",   64'(bus.sent_pause_mode),     64'd2);
        tick();
        chk("t1_one_cyc", 64'(bus.sent_config_vld), 64'd0);
        repeat (4) tick();

        // Frame to ch0 blocked by pfull for 20 cycles.
        bus.sent_fifo_pfull = 2'b01;
        put(1'b1, 8'd0, mk_frm(32'hA5A5_1234));
        repeat (19) tick();
        bus.sent_fifo_pfull = 2'b00;
        wait_strobe(10, n);
        chk("t2_latency_le3", 64'(n <= 3),                 64'd1);
        chk("t2_frm_vld",     64'(bus.sent_frame_vld),     64'd1);
        chk("t2_data",        64'(bus.sent_frame_data),    64'hA5A5_1234);
        chk("t2_ctick_hold",  64'(bus.sent_ctick_len),     64'd10);
        chk("t2_err_tmo",     64'(bus.err_timeout),        64'd0);
        repeat (4) tick();

        // Config to ch0 never ready: timed out; the ch1 frame behind it follows.
        bus.sent_ready = 2'b10;
        t0 = tb_cyc;
        put(1'b0, 8'd0, mk_cfg(8'hEE, 8'h01, 2'd1, 16'h0F0F, 1'b0));
        put(1'b1, 8'd1, mk_frm(32'h0000_00C3));
        while (!bus.err_timeout && (tb_cyc - t0) < 70) tick();
        chk("t3_tmo_cycle", 64'(tb_cyc - t0), 64'd52);
        chk("t3_ctick_kept", 64'(bus.sent_ctick_len), 64'd10);
        repeat (2) tick();
        chk("t3_next_frm", 64'(bus.sent_frame_vld),      64'd1);
        chk("t3_next_ch",  64'(bus.sent_config_channel), 64'd1);
        chk("t3_next_dat", 64'(bus.sent_frame_data),     64'hC3);
        repeat (4) tick();

        // Bad channel, with err_clr landing on the same cycle as the set.
        bus.sent_ready = 2'b11;
        put(1'b0, 8'd5, mk_cfg(8'h77, 8'h77, 2'd3, 16'hFFFF, 1'b1));
        put(1'b1, 8'd1, mk_frm(32'h1111_2222));
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t4_badch_prio", 64'(bus.err_badch),   64'd1);
        chk("t4_tmo_clr",    64'(bus.err_timeout), 64'd0);
        repeat (2) tick();
        chk("t4_frm_vld",  64'(bus.sent_frame_vld),      64'd1);
        chk("t4_frm_ch",   64'(bus.sent_config_channel), 64'd1);
        chk("t4_frm_data", 64'(bus.sent_frame_data),     64'h1111_2222);
        repeat (4) tick();

        // Overflow behind a blocked head, then in-order drain.
        bus.sent_ready = 2'b10;
        put(1'b0, 8'd0, mk_cfg(8'h11, 8'h22, 2'd1, 16'h3344, 1'b1));
        put(1'b1, 8'd1, mk_frm(32'h0000_0001));
        put(1'b0, 8'd1, mk_cfg(8'h55, 8'h66, 2'd0, 16'h7788, 1'b0));
        put(1'b1, 8'd0, mk_frm(32'hDEAD_BEEF));
        chk("t5_full4",   64'(bus.cmd_full),     64'd1);
        chk("t5_no_ovf",  64'(bus.err_overflow), 64'd0);
        put(1'b1, 8'd1, mk_frm(32'h0000_0BAD));
        put(1'b1, 8'd1, mk_frm(32'h0000_0BAE));
        chk("t5_ovf",     64'(bus.err_overflow), 64'd1);
        chk("t5_full6",   64'(bus.cmd_full),     64'd1);
        bus.sent_ready = 2'b11;
        wait_strobe(12, n);
        chk("t5_s0", 64'({bus.sent_config_vld, bus.sent_config_channel, bus.sent_ctick_len}), 64'h1_00_11);
        wait_strobe(12, n);
        chk("t5_s1", 64'({bus.sent_frame_vld, bus.sent_config_channel, bus.sent_frame_data}), 64'h1_01_0000_0001);
        wait_strobe(12, n);
        chk("t5_s2", 64'({bus.sent_config_vld, bus.sent_config_channel, bus.sent_ctick_len}), 64'h1_01_55);
        wait_strobe(12, n);
        chk("t5_s3", 64'({bus.sent_frame_vld, bus.sent_config_channel, bus.sent_frame_data}), 64'h1_00_DEAD_BEEF);
        cnt = 0;
        repeat (10) begin
            tick();
            if (strobe()) cnt++;
        end
        chk("t5_no_extra", 64'(cnt), 64'd0);
        chk("t5_drained",  64'(bus.cmd_full), 64'd0);

        // Reset while commands are queued and the head is waiting.
        bus.sent_ready = 2'b10;
        put(1'b0, 8'd7, mk_cfg(8'h01, 8'h01, 2'd1, 16'h0001, 1'b1));
        put(1'b0, 8'd0, mk_cfg(8'h02, 8'h02, 2'd1, 16'h0002, 1'b1));
        put(1'b0, 8'd0, mk_cfg(8'h03, 8'h03, 2'd1, 16'h0003, 1'b1));
        put(1'b0, 8'd0, mk_cfg(8'h04, 8'h04, 2'd1, 16'h0004, 1'b1));
        repeat (2) tick();
        chk("t6_pre_badch", 64'(bus.err_badch), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_full",   64'(bus.cmd_full), 64'd0);
        chk("t6_rst_vld",    64'({bus.sent_config_vld, bus.sent_frame_vld}), 64'd0);
        chk("t6_rst_fields", 64'({bus.sent_config_channel, bus.sent_ctick_len, bus.sent_ltick_len,
                                  bus.sent_pause_mode, bus.sent_crc_mode}), 64'd0);
        chk("t6_rst_plen",   64'(bus.sent_pause_len),  64'd0);
        chk("t6_rst_fdata",  64'(bus.sent_frame_data), 64'd0);
        chk("t6_rst_errs",   64'({bus.err_overflow, bus.err_badch, bus.err_timeout}), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        bus.sent_ready = 2'b11;
        cnt = 0;
        repeat (12) begin
            tick();
            if (strobe()) cnt++;
        end
        chk("t6_no_strobe", 64'(cnt), 64'd0);
        chk("t6_empty",     64'(bus.cmd_full), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
